// File: rtl/mux_pkg.sv
// ============================================================================
// Module   : mux_pkg
// Brief    : Shared constants for the mux_2x1 selector and its optional counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

package mux_pkg;

  localparam int   DEFAULT_WIDTH = 4;
  localparam logic SEL_A         = 1'b0;
  localparam logic SEL_B         = 1'b1;
  localparam int   TOGGLE_CNT_W  = 16;

endpackage

`default_nettype wire

// File: rtl/mux_2x1_comb.sv
// ============================================================================
// Module   : mux_2x1_comb
// Brief    : Pure combinational 2:1 selector; an unknown select yields all-X.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_2x1_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] ia,
  input  logic [WIDTH-1:0] ib,
  input  logic             sel,
  output logic [WIDTH-1:0] s
);

  // The default arm is only reachable with an X/Z select and propagates X.
  always_comb begin
    s = 'x;
    case (sel)
      SEL_A:   s = ia;
      SEL_B:   s = ib;
      default: s = 'x;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mux_2x1.sv
// ============================================================================
// Module   : mux_2x1
// Brief    : 2:1 selector with combinational and registered outputs.
//            MUX_SEL_COUNT_EN adds a saturating select-toggle counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

module mux_2x1
  import mux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [WIDTH-1:0]        ia,
  input  logic [WIDTH-1:0]        ib,
  input  logic                    sel,
  input  logic                    in_valid,
  output logic [WIDTH-1:0]        s,
  output logic [WIDTH-1:0]        s_q,
  output logic                    out_valid
`ifdef MUX_SEL_COUNT_EN
  ,
  output logic [TOGGLE_CNT_W-1:0] sel_toggles
`endif
);

  mux_2x1_comb #(
    .WIDTH (WIDTH)
  ) u_comb (
    .ia  (ia),
    .ib  (ib),
    .sel (sel),
    .s   (s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        s_q <= s;
      end
    end
  end

`ifdef MUX_SEL_COUNT_EN
  logic r_prev_sel;
  logic r_have_prev;
  logic w_toggle;

  // The first capture after reset only seeds r_prev_sel; it never counts.
  assign w_toggle = in_valid && r_have_prev && (sel != r_prev_sel) &&
                    (sel_toggles != {TOGGLE_CNT_W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev_sel  <= SEL_A;
      r_have_prev <= 1'b0;
      sel_toggles <= '0;
    end else begin
      if (in_valid) begin
        r_prev_sel  <= sel;
        r_have_prev <= 1'b1;
      end
      if (w_toggle) begin
        sel_toggles <= sel_toggles + 1'b1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_mux_2x1.sv
// ============================================================================
// Module   : tb_mux_2x1
// Brief    : Scoreboard bench for mux_2x1 (covers MUX_SEL_COUNT_EN when defined).
// Revision : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mux_2x1;
  import mux_pkg::*;

  localparam int W = 4;

  typedef struct packed {
    logic         v;
    logic [W-1:0] d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] ia;
  logic [W-1:0] ib;
  logic         sel;
  logic         in_valid;
  logic [W-1:0] s;
  logic [W-1:0] s_q;
  logic         out_valid;

  exp_t         sb_q[$];
  int           n_cmp = 0;
  int           n_err = 0;
  logic [W-1:0] m_q;
  logic         m_prev;
  logic         m_have;
  int           m_cnt;

`ifdef MUX_SEL_COUNT_EN
  logic [TOGGLE_CNT_W-1:0] sel_toggles;
`endif

  mux_2x1 #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ia          (ia),
    .ib          (ib),
    .sel         (sel),
    .in_valid    (in_valid),
    .s           (s),
    .s_q         (s_q),
    .out_valid   (out_valid)
`ifdef MUX_SEL_COUNT_EN
    ,
    .sel_toggles (sel_toggles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q    = '0;
    m_prev = 1'b0;
    m_have = 1'b0;
    m_cnt  = 0;
  endtask

  task automatic model_capture(input logic sl, input logic [W-1:0] d);
    m_q = d;
    if (m_have && (sl != m_prev) && (m_cnt < 65535)) m_cnt++;
    m_prev = sl;
    m_have = 1'b1;
  endtask

  task automatic check_regs();
`ifdef MUX_SEL_COUNT_EN
    chk("sel_toggles", 32'(sel_toggles), 32'(m_cnt));
`endif
  endtask

  // Drive one cycle of stimulus, check the combinational result, then the
  // registered result one edge later via the scoreboard.
  task automatic step(input logic v, input logic sl, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t         e;
    logic [W-1:0] mux;
    in_valid = v;
    sel      = sl;
    ia       = a;
    ib       = b;
    #1;
    mux = sl ? b : a;
    chk("s_comb", 32'(s), 32'(mux));
    if (v) model_capture(sl, mux);
    e.v = v;
    e.d = m_q;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("s_q", 32'(s_q), 32'(e.d));
    chk("out_valid", 32'(out_valid), 32'(e.v));
    check_regs();
  endtask

  initial begin
    model_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    sel      = 1'b1;
    ia       = 4'h1;
    ib       = 4'h2;
    #1;
    chk("s_in_reset", 32'(s), 32'h2);
    @(posedge clk);
    #1;
    chk("s_q_in_reset", 32'(s_q), 32'h0);
    chk("out_valid_in_reset", 32'(out_valid), 32'h0);
    check_regs();
    rst = 1'b0;

    step(1'b1, 1'b0, 4'h1, 4'h2);
    step(1'b1, 1'b1, 4'hA, 4'h5);
    step(1'b1, 1'b0, 4'hA, 4'h5);
    step(1'b1, 1'b1, 4'hA, 4'h5);
    step(1'b0, 1'b0, 4'hA, 4'h5);
    step(1'b0, 1'b1, 4'h3, 4'h9);
    step(1'b1, 1'b0, 4'h7, 4'h7);
    step(1'b1, 1'b1, 4'h7, 4'h7);
    step(1'b1, 1'b0, 4'h3, 4'hC);

    // Asynchronous reset pulse between edges while out_valid is high.
    #2;
    rst = 1'b1;
    #1;
    chk("s_q_async_rst", 32'(s_q), 32'h0);
    chk("out_valid_async_rst", 32'(out_valid), 32'h0);
    model_reset();
    check_regs();
    in_valid = 1'b0;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("s_q_after_rst", 32'(s_q), 32'h0);
    chk("out_valid_after_rst", 32'(out_valid), 32'h0);

    step(1'b1, 1'b0, 4'h3, 4'hC);
    step(1'b1, 1'b1, 4'h3, 4'hC);
    step(1'b1, 1'b1, 4'h3, 4'hC);
    step(1'b1, 1'b0, 4'h3, 4'hC);
`ifdef MUX_SEL_COUNT_EN
    chk("toggles_seq", 32'(sel_toggles), 32'd2);

    // Long toggle run to reach and hold saturation.
    for (int i = 0; i < 65540; i++) begin
      in_valid = 1'b1;
      sel      = ~sel;
      model_capture(sel, sel ? ib : ia);
      @(posedge clk);
      #1;
    end
    chk("toggles_sat", 32'(sel_toggles), 32'hFFFF);
    chk("s_q_after_sat", 32'(s_q), 32'(m_q));
    step(1'b1, ~sel, 4'h3, 4'hC);
`endif

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
